// File: rtl/eye_centroid_divider_if.sv
// ============================================================================
// Module   : eye_centroid_divider_if
// Brief    : Sum inputs and centroid results between accumulator, divider and register block.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface eye_centroid_divider_if #(
    parameter int SUM_S_WIDTH  = 20,
    parameter int SUM_XY_WIDTH = 28
);
    logic                    iVSYNC;
    logic [SUM_S_WIDTH-1:0]  iSUM_S;
    logic [SUM_XY_WIDTH-1:0] iSUM_SX;
    logic [SUM_XY_WIDTH-1:0] iSUM_SY;
    logic [SUM_XY_WIDTH-1:0] oQUOTIENT_SX;
    logic [SUM_XY_WIDTH-1:0] oQUOTIENT_SY;
    logic [SUM_S_WIDTH-1:0]  oFRACTIONAL_SX;
    logic [SUM_S_WIDTH-1:0]  oFRACTIONAL_SY;
    logic                    oBUSY;
    logic                    oDONE;
    logic                    oDIV_ZERO;

    modport slave (
        input  iVSYNC, iSUM_S, iSUM_SX, iSUM_SY,
        output oQUOTIENT_SX, oQUOTIENT_SY, oFRACTIONAL_SX, oFRACTIONAL_SY,
               oBUSY, oDONE, oDIV_ZERO
    );

    modport master (
        output iVSYNC, iSUM_S, iSUM_SX, iSUM_SY,
        input  oQUOTIENT_SX, oQUOTIENT_SY, oFRACTIONAL_SX, oFRACTIONAL_SY,
               oBUSY, oDONE, oDIV_ZERO
    );
endinterface

`default_nettype wire

// File: rtl/eye_centroid_divider.sv
// ============================================================================
// Module   : eye_centroid_divider
// Brief    : Per-frame pupil centroid, restoring divide of SUM_SX/SUM_S and SUM_SY/SUM_S.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eye_centroid_divider #(
    parameter int SUM_S_WIDTH  = 20,
    parameter int SUM_XY_WIDTH = 28
) (
    input  wire                    CLK,
    input  wire                    RST_N,
    eye_centroid_divider_if.slave  bus
);
    localparam int CW = $clog2(SUM_XY_WIDTH + 1);
    localparam logic [CW-1:0] c_ITER = CW'(SUM_XY_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    vsync_q;
    logic [SUM_S_WIDTH-1:0]  div_q, div_d;
    logic [SUM_XY_WIDTH-1:0] dvx_q, dvx_d, dvy_q, dvy_d;
    logic [SUM_S_WIDTH:0]    rx_q, rx_d, ry_q, ry_d;
    logic [SUM_XY_WIDTH-1:0] qx_q, qx_d, qy_q, qy_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SUM_XY_WIDTH-1:0] oqx_q, oqx_d, oqy_q, oqy_d;
    logic [SUM_S_WIDTH-1:0]  ofx_q, ofx_d, ofy_q, ofy_d;
    logic                    busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic                    w_start;
    logic [SUM_S_WIDTH:0]    w_shx, w_shy, w_div_ext;
    logic                    w_gex, w_gey;

    assign w_start   = bus.iVSYNC & ~vsync_q;
    // Partial remainder is always < divisor, so its top bit is free for the shift-in.
    assign w_shx     = {rx_q[SUM_S_WIDTH-1:0], dvx_q[SUM_XY_WIDTH-1]};
    assign w_shy     = {ry_q[SUM_S_WIDTH-1:0], dvy_q[SUM_XY_WIDTH-1]};
    assign w_div_ext = {1'b0, div_q};
    assign w_gex     = (w_shx >= w_div_ext);
    assign w_gey     = (w_shy >= w_div_ext);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        dvx_d   = dvx_q;
        dvy_d   = dvy_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        cnt_d   = cnt_q;
        oqx_d   = oqx_q;
        oqy_d   = oqy_q;
        ofx_d   = ofx_q;
        ofy_d   = ofy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    div_d   = bus.iSUM_S;
                    dvx_d   = bus.iSUM_SX;
                    dvy_d   = bus.iSUM_SY;
                    rx_d    = '0;
                    ry_d    = '0;
                    qx_d    = '0;
                    qy_d    = '0;
                    cnt_d   = c_ITER;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rx_d  = w_gex ? (w_shx - w_div_ext) : w_shx;
                ry_d  = w_gey ? (w_shy - w_div_ext) : w_shy;
                qx_d  = {qx_q[SUM_XY_WIDTH-2:0], w_gex};
                qy_d  = {qy_q[SUM_XY_WIDTH-2:0], w_gey};
                dvx_d = dvx_q << 1;
                dvy_d = dvy_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (div_q == '0) begin
                    oqx_d = '0;
                    oqy_d = '0;
                    ofx_d = '0;
                    ofy_d = '0;
                    dz_d  = 1'b1;
                end else begin
                    oqx_d = qx_q;
                    oqy_d = qy_q;
                    ofx_d = rx_q[SUM_S_WIDTH-1:0];
                    ofy_d = ry_q[SUM_S_WIDTH-1:0];
                    dz_d  = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
            div_q   <= '0;
            dvx_q   <= '0;
            dvy_q   <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            cnt_q   <= '0;
            oqx_q   <= '0;
            oqy_q   <= '0;
            ofx_q   <= '0;
            ofy_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= bus.iVSYNC;
            div_q   <= div_d;
            dvx_q   <= dvx_d;
            dvy_q   <= dvy_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            cnt_q   <= cnt_d;
            oqx_q   <= oqx_d;
            oqy_q   <= oqy_d;
            ofx_q   <= ofx_d;
            ofy_q   <= ofy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.oQUOTIENT_SX   = oqx_q;
    assign bus.oQUOTIENT_SY   = oqy_q;
    assign bus.oFRACTIONAL_SX = ofx_q;
    assign bus.oFRACTIONAL_SY = ofy_q;
    assign bus.oBUSY          = busy_q;
    assign bus.oDONE          = done_q;
    assign bus.oDIV_ZERO      = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_eye_centroid_divider.sv
// ============================================================================
// Module   : tb_eye_centroid_divider
// Brief    : Directed vector table plus hand sequences and random frames for the centroid divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eye_centroid_divider;
    localparam int SW = 20;
    localparam int XW = 28;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    eye_centroid_divider_if #(.SUM_S_WIDTH(SW), .SUM_XY_WIDTH(XW)) bus ();

    eye_centroid_divider #(.SUM_S_WIDTH(SW), .SUM_XY_WIDTH(XW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] s;
        logic [XW-1:0] sx;
        logic [XW-1:0] sy;
        logic [XW-1:0] qx;
        logic [SW-1:0] rx;
        logic [XW-1:0] qy;
        logic [SW-1:0] ry;
        logic          dz;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic scramble_inputs();
        logic [31:0] t;
        t = $urandom; bus.iSUM_S  = t[SW-1:0];
        t = $urandom; bus.iSUM_SX = t[XW-1:0];
        t = $urandom; bus.iSUM_SY = t[XW-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one frame, scrambles the sum inputs during CALC, and checks timing.
    task automatic do_frame(input logic [SW-1:0] s, input logic [XW-1:0] sx, input logic [XW-1:0] sy);
        int lat;
        int busy_n;
        bit seen;
        bus.iSUM_S  = s;
        bus.iSUM_SX = sx;
        bus.iSUM_SY = sy;
        bus.iVSYNC  = 1'b1;
        tick();
        bus.iVSYNC = 1'b0;
        busy_n = bus.oBUSY ? 1 : 0;
        lat    = 0;
        seen   = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            scramble_inputs();
            tick();
            if (bus.oDONE) begin
                seen = 1'b1;
                lat  = c;
            end else if (bus.oBUSY) begin
                busy_n++;
            end
        end
        chk("latency", lat, 29);
        chk("busy_cycles", busy_n, 29);
        chk("busy_low_at_done", bus.oBUSY, 0);
        tick();
        chk("done_single_pulse", bus.oDONE, 0);
    endtask

    task automatic chk_results(input string tag, input vec_t v);
        chk({tag, "_qx"}, bus.oQUOTIENT_SX, v.qx);
        chk({tag, "_rx"}, bus.oFRACTIONAL_SX, v.rx);
        chk({tag, "_qy"}, bus.oQUOTIENT_SY, v.qy);
        chk({tag, "_ry"}, bus.oFRACTIONAL_SY, v.ry);
        chk({tag, "_dz"}, bus.oDIV_ZERO, v.dz);
    endtask

    initial begin
        vec_t zero_v;
        vec_t v;
        int   dn;
        logic [31:0] t;
        logic [63:0] prod;

        checks   = 0;
        failures = 0;
        //         s         sx          sy        qx          rx        qy        ry        dz
        vecs[0] = '{20'd100,  28'd12345,  28'd9999, 28'd123,    20'd45,   28'd99,   20'd99,   1'b0};
        vecs[1] = '{20'd1,    28'hFFFFFFF, 28'd0,   28'hFFFFFFF, 20'd0,   28'd0,    20'd0,    1'b0};
        vecs[2] = '{20'hFFFFF, 28'hFFFFFFF, 28'h12345, 28'h100, 20'hFF,   28'd0,    20'h12345, 1'b0};
        vecs[3] = '{20'd0,    28'd500,    28'd7,    28'd0,      20'd0,    28'd0,    20'd0,    1'b1};
        vecs[4] = '{20'd5,    28'd500,    28'd33,   28'd100,    20'd0,    28'd6,    20'd3,    1'b0};
        vecs[5] = '{20'd7,    28'd1000,   28'd50,   28'd142,    20'd6,    28'd7,    20'd1,    1'b0};
        zero_v  = '{20'd0, 28'd0, 28'd0, 28'd0, 20'd0, 28'd0, 20'd0, 1'b0};

        rst_n       = 1'b0;
        bus.iVSYNC  = 1'b0;
        bus.iSUM_S  = '0;
        bus.iSUM_SX = '0;
        bus.iSUM_SY = '0;
        repeat (3) tick();
        chk_results("reset", zero_v);
        chk("reset_busy", bus.oBUSY, 0);
        chk("reset_done", bus.oDONE, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_frame(vecs[i].s, vecs[i].sx, vecs[i].sy);
            chk_results($sformatf("vec%0d", i), vecs[i]);
        end

        // Restarts at T0+10 and in the DONE cycle must both be ignored.
        bus.iSUM_S  = 20'd100;
        bus.iSUM_SX = 28'd12345;
        bus.iSUM_SY = 28'd9999;
        bus.iVSYNC  = 1'b1;
        tick();
        bus.iVSYNC = 1'b0;
        dn = 0;
        for (int k = 1; k <= 29; k++) begin
            scramble_inputs();
            if (k == 10) begin
                bus.iVSYNC  = 1'b1;
                bus.iSUM_S  = 20'd3;
                bus.iSUM_SX = 28'd77;
                bus.iSUM_SY = 28'd88;
            end
            if (k == 12) bus.iVSYNC = 1'b0;
            if (k == 29) bus.iVSYNC = 1'b1;
            tick();
            if (bus.oDONE) dn++;
        end
        chk("rej_done_at_T29", bus.oDONE, 1);
        chk_results("rej", vecs[0]);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.oDONE) dn++;
            if (k == 0) chk("rej_no_restart_busy", bus.oBUSY, 0);
        end
        chk("rej_done_count", dn, 1);
        bus.iVSYNC = 1'b0;
        tick();

        // Reset in the middle of CALC.
        bus.iSUM_S  = 20'd7;
        bus.iSUM_SX = 28'd1000;
        bus.iSUM_SY = 28'd50;
        bus.iVSYNC  = 1'b1;
        tick();
        bus.iVSYNC = 1'b0;
        repeat (14) tick();
        rst_n = 1'b0;
        tick();
        chk("rstmid_busy", bus.oBUSY, 0);
        chk_results("rstmid", zero_v);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.oDONE) dn++;
        end
        chk("rstmid_no_done", dn, 0);
        do_frame(vecs[5].s, vecs[5].sx, vecs[5].sy);
        chk_results("after_rst", vecs[5]);

        for (int n = 0; n < 1000; n++) begin
            t = $urandom;
            v.s = (t[1:0] == 2'b00) ? SW'($urandom_range(0, 15)) : t[SW+1:2];
            t = $urandom; v.sx = t[XW-1:0];
            t = $urandom; v.sy = t[XW-1:0];
            do_frame(v.s, v.sx, v.sy);
            if (v.s == '0) begin
                chk("rnd_dz", bus.oDIV_ZERO, 1);
                chk("rnd_dz_q", {bus.oQUOTIENT_SX, bus.oQUOTIENT_SY}, 0);
            end else begin
                chk("rnd_dz_clr", bus.oDIV_ZERO, 0);
                prod = 64'(bus.oQUOTIENT_SX) * 64'(v.s) + 64'(bus.oFRACTIONAL_SX);
                chk("rnd_x_identity", prod, 64'(v.sx));
                chk("rnd_x_rem_lt", (bus.oFRACTIONAL_SX < v.s) ? 1 : 0, 1);
                prod = 64'(bus.oQUOTIENT_SY) * 64'(v.s) + 64'(bus.oFRACTIONAL_SY);
                chk("rnd_y_identity", prod, 64'(v.sy));
                chk("rnd_y_rem_lt", (bus.oFRACTIONAL_SY < v.s) ? 1 : 0, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
